cmd_seq_ctrl: RTL and testbench
===============================

Name: cmd_seq_ctrl

Overview:
- Fetch/branch sequencer that drives the command-pointer block (opcode, addr_to) and the instruction memory.
- Consumes the pointer's addr_point and ready outputs. Each cycle it decides whether the pointer increments, jumps absolute, or jumps relative.
- Control-class instructions are resolved here: jumps, loop counter, halt.
- Normal instructions are emitted downstream as a one-cycle strobe.

Parameters:
BUS_WIDTH, 32, width of addr_point/addr_to/instr_addr
INSTR_WIDTH, 32, instruction word width; bits [INSTR_WIDTH-1 -: 3] = class, remaining low bits = operand
LOOP_WIDTH, 16, loop counter width (operand[LOOP_WIDTH-1:0] used by LOOP)
START_ADDR, 0, program entry address

Ports:
clk  input  1  clock; all state on rising edge
nreset  input  1  asynchronous active-low reset
start  input  1  level; begin/restart execution
addr_point  input  BUS_WIDTH  current pointer value from command-pointer block
ptr_ready  input  1  ready from command-pointer block
opcode  output  3  000 NUL(increment), 001 JMP, 010 SJF, 100 SJB to pointer block
addr_to  output  BUS_WIDTH  jump target / offset to pointer block
imem_addr  output  BUS_WIDTH  = addr_point (combinational)
imem_rdata  input  INSTR_WIDTH  sync memory data, 1-cycle read latency
instr  output  INSTR_WIDTH  emitted normal instruction
instr_addr  output  BUS_WIDTH  address of emitted instruction
instr_valid  output  1  one-cycle strobe; no backpressure
halted  output  1  high in HALTED state

Behaviour:
- Interface: one clock clk; reset nreset is asynchronous and active-low.
- Reset (async):
  - State = IDLE; slot_valid = 0; loop_cnt = 0; fetch_addr_q = 0; halt_addr_q = 0.
  - Outputs: opcode = 001, addr_to = START_ADDR, instr_valid = 0, halted = 0.
- Pointer model:
  - The pointer updates every clock per opcode.
  - Relative targets are computed from the pointer's current value. For a branch decoded at address A while the pointer holds A+1: SJF target = A+1+off, SJB target = A+1-off. Modulo 2^BUS_WIDTH wrap.
- Operand: low INSTR_WIDTH-3 bits, zero-extended/truncated to BUS_WIDTH.
- Fetch slot registers: slot_valid and fetch_addr_q (<= addr_point every cycle). They describe the imem_rdata present in the current cycle.
- IDLE:
  - Drive opcode = JMP, addr_to = START_ADDR, which pins the pointer.
  - If start & ptr_ready: drive opcode = NUL instead, slot_valid <= 1, go to RUN.
  - Start is ignored while ptr_ready = 0.
- RUN, slot_valid = 0 (squashed slot): opcode = NUL, no emit, slot_valid <= 1.
- RUN, slot_valid = 1: decode the imem_rdata class; all outputs below are combinational in the same cycle.
  - 000 normal: instr_valid = 1, instr = rdata, instr_addr = fetch_addr_q; opcode NUL; slot_valid <= 1.
  - 001 JMP / 010 SJF / 100 SJB: opcode = class, addr_to = operand; slot_valid <= 0 (the wrong-path word is squashed). Applies even for offset 0.
  - 011 LOOP: loop_cnt <= operand[LOOP_WIDTH-1:0]; opcode NUL; slot_valid <= 1.
  - 101 DJNZ:
    - If loop_cnt == 0: loop_cnt stays 0; not taken.
    - Otherwise loop_cnt <= loop_cnt-1. Taken iff loop_cnt-1 != 0.
    - Taken: opcode SJB, addr_to = operand, slot_valid <= 0. Not taken: NUL, slot_valid <= 1.
  - 111 HALT: opcode JMP, addr_to = fetch_addr_q, halt_addr_q <= fetch_addr_q, slot_valid <= 0, go to HALTED.
  - 110 reserved: treated as NUL; not emitted; slot_valid <= 1.
- Control-class instructions are never emitted on instr_valid.
- HALTED:
  - halted = 1; opcode JMP, addr_to = halt_addr_q (pointer pinned); no emit.
  - If start: opcode JMP, addr_to = START_ADDR, go to IDLE. A fresh start is then needed to run.
- Reset mid-operation: immediate return to reset values. Any in-flight slot is discarded.
- Cycle cost: taken branch/HALT costs 1 bubble cycle; DJNZ loop body throughput = body length + 2 cycles per iteration.

Test Plan:
- Reset then start=1 held, START_ADDR=0x10, mem[0x10..0x12] = normal -> instr_valid pulses at instr_addr 0x10, 0x11, 0x12 on consecutive cycles starting 1 cycle after start accepted; start ignored on the first cycle while ptr_ready=0.
- mem[0x10] = JMP 0x40, mem[0x40] = normal -> opcode=001 with addr_to=0x40 for 1 cycle; word at 0x11 not emitted; next emit instr_addr=0x40 two cycles after JMP decode.
- mem[0x20] = SJF 3 -> next emitted address 0x24. mem[0x30] = SJB 5 -> next emitted address 0x2C.
- mem[0x10] = LOOP 3, mem[0x11] = normal X, mem[0x12] = DJNZ 2 -> X emitted exactly 3 times, then fall-through to 0x13; loop_cnt ends at 0. Repeat with LOOP 0 -> X emitted once.
- mem[0x15] = HALT -> halted=1, opcode=JMP/addr_to=0x15 held for 10+ cycles, no instr_valid; start -> IDLE; second start resumes emitting at 0x10.
- Assert nreset mid-loop -> outputs return to opcode=001, addr_to=START_ADDR, instr_valid=0, halted=0 asynchronously; loop_cnt=0 after release.

Source files
------------

// File: rtl/cmd_seq_ctrl.sv
// Fetch/branch sequencer: steers the command pointer, squashes wrong-path
// fetches, resolves jumps/loops/halt and strobes normal instructions out.
module cmd_seq_ctrl #(
    parameter int                   BUS_WIDTH   = 32,
    parameter int                   INSTR_WIDTH = 32,
    parameter int                   LOOP_WIDTH  = 16,
    parameter logic [BUS_WIDTH-1:0] START_ADDR  = '0
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   start,
    input  logic [BUS_WIDTH-1:0]   addr_point,
    input  logic                   ptr_ready,
    output logic [2:0]             opcode,
    output logic [BUS_WIDTH-1:0]   addr_to,
    output logic [BUS_WIDTH-1:0]   imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [BUS_WIDTH-1:0]   instr_addr,
    output logic                   instr_valid,
    output logic                   halted
);

    localparam int OPW = INSTR_WIDTH - 3;

    localparam logic [2:0] C_NUL  = 3'b000;
    localparam logic [2:0] C_JMP  = 3'b001;
    localparam logic [2:0] C_SJF  = 3'b010;
    localparam logic [2:0] C_LOOP = 3'b011;
    localparam logic [2:0] C_SJB  = 3'b100;
    localparam logic [2:0] C_DJNZ = 3'b101;
    localparam logic [2:0] C_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic                   r_slot_valid;
    logic                   w_slot_n;
    logic [LOOP_WIDTH-1:0]  r_loop_cnt;
    logic [LOOP_WIDTH-1:0]  w_cnt_n;
    logic [LOOP_WIDTH-1:0]  w_cnt_dec;
    logic [BUS_WIDTH-1:0]   r_fetch_addr;
    logic [BUS_WIDTH-1:0]   r_halt_addr;
    logic [BUS_WIDTH-1:0]   w_halt_n;
    logic [BUS_WIDTH-1:0]   w_operand;
    logic [2:0]             w_class;
    logic [2:0]             w_opcode;
    logic [BUS_WIDTH-1:0]   w_addr_to;
    logic                   w_valid;

    assign w_class = imem_rdata[INSTR_WIDTH-1 -: 3];

    generate
        if (OPW >= BUS_WIDTH) begin : g_trunc
            assign w_operand = imem_rdata[BUS_WIDTH-1:0];
        end else begin : g_zext
            assign w_operand = {{(BUS_WIDTH-OPW){1'b0}}, imem_rdata[OPW-1:0]};
        end
    endgenerate

    assign w_cnt_dec = r_loop_cnt - {{(LOOP_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state      <= S_IDLE;
            r_slot_valid <= 1'b0;
            r_loop_cnt   <= '0;
            r_fetch_addr <= '0;
            r_halt_addr  <= '0;
        end else begin
            r_state      <= w_next;
            r_slot_valid <= w_slot_n;
            r_loop_cnt   <= w_cnt_n;
            r_fetch_addr <= addr_point;
            r_halt_addr  <= w_halt_n;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_slot_n  = r_slot_valid;
        w_cnt_n   = r_loop_cnt;
        w_halt_n  = r_halt_addr;
        w_opcode  = C_JMP;
        w_addr_to = START_ADDR;
        w_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_slot_n = 1'b0;
                if (start && ptr_ready) begin
                    w_opcode = C_NUL;
                    w_slot_n = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_opcode = C_NUL;
                w_slot_n = 1'b1;
                if (r_slot_valid) begin
                    case (w_class)
                        C_NUL: w_valid = 1'b1;
                        C_JMP, C_SJF, C_SJB: begin
                            w_opcode  = w_class;
                            w_addr_to = w_operand;
                            w_slot_n  = 1'b0;
                        end
                        C_LOOP: w_cnt_n = w_operand[LOOP_WIDTH-1:0];
                        C_DJNZ: begin
                            // an exhausted counter falls through and stays at zero
                            if (r_loop_cnt != '0) begin
                                w_cnt_n = w_cnt_dec;
                                if (w_cnt_dec != '0) begin
                                    w_opcode  = C_SJB;
                                    w_addr_to = w_operand;
                                    w_slot_n  = 1'b0;
                                end
                            end
                        end
                        C_HALT: begin
                            w_opcode  = C_JMP;
                            w_addr_to = r_fetch_addr;
                            w_halt_n  = r_fetch_addr;
                            w_slot_n  = 1'b0;
                            w_next    = S_HALTED;
                        end
                        default: ;
                    endcase
                end
            end
            S_HALTED: begin
                w_slot_n  = 1'b0;
                w_addr_to = r_halt_addr;
                if (start) begin
                    w_addr_to = START_ADDR;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign opcode      = w_opcode;
    assign addr_to     = w_addr_to;
    assign imem_addr   = addr_point;
    assign instr       = imem_rdata;
    assign instr_addr  = r_fetch_addr;
    assign instr_valid = w_valid;
    assign halted      = (r_state == S_HALTED);

endmodule

// File: tb/tb_cmd_seq_ctrl.sv
// Directed bench: pointer/memory models around cmd_seq_ctrl with an
// emission scoreboard of expected instruction addresses.
module tb_cmd_seq_ctrl;

    localparam logic [31:0] SA = 32'h10;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic        ptr_ready;
    logic [31:0] addr_point;
    logic [2:0]  opcode;
    logic [31:0] addr_to;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_addr;
    logic        instr_valid;
    logic        halted;

    logic [31:0] mem [0:255];
    logic [31:0] sbq [$];
    logic        sb_en;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_tot  = 0;

    always #5 clk = ~clk;

    cmd_seq_ctrl #(
        .BUS_WIDTH  (32),
        .INSTR_WIDTH(32),
        .LOOP_WIDTH (16),
        .START_ADDR (SA)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .start      (start),
        .addr_point (addr_point),
        .ptr_ready  (ptr_ready),
        .opcode     (opcode),
        .addr_to    (addr_to),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_addr (instr_addr),
        .instr_valid(instr_valid),
        .halted     (halted)
    );

    always @(posedge clk or negedge nreset) begin
        if (!nreset) addr_point <= '0;
        else begin
            case (opcode)
                3'b000:  addr_point <= addr_point + 32'd1;
                3'b001:  addr_point <= addr_to;
                3'b010:  addr_point <= addr_point + addr_to;
                3'b100:  addr_point <= addr_point - addr_to;
                default: addr_point <= addr_point;
            endcase
        end
    end

    always @(posedge clk) imem_rdata <= mem[imem_addr[7:0]];

    function automatic logic [31:0] mk(input logic [2:0] c, input int op);
        logic [31:0] v;
        v = op;
        return {c, v[28:0]};
    endfunction

    function automatic logic [31:0] nrm(input logic [31:0] a);
        return mk(3'b000, 32'h01AB_0000 + a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (nreset && sb_en && instr_valid) begin
            logic [31:0] ea;
            check("sb_avail", 64'(sbq.size() > 0), 64'd1);
            if (sbq.size() > 0) begin
                ea = sbq.pop_front();
                check("sb_addr", 64'(instr_addr), 64'(ea));
                check("sb_instr", 64'(instr), 64'(nrm(ea)));
            end
        end
    end

    task automatic fill_halt();
        for (int i = 0; i < 256; i++) mem[i] = mk(3'b111, i);
    endtask

    task automatic do_reset();
        @(negedge clk);
        nreset = 1'b0;
        start  = 1'b0;
        sbq.delete();
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
    endtask

    task automatic go();
        start     = 1'b1;
        ptr_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_halt(input string tag);
        for (int i = 0; i < 60; i++) begin
            if (halted) break;
            @(negedge clk);
        end
        check(tag, 64'(halted), 64'd1);
    endtask

    initial begin
        nreset    = 1'b0;
        start     = 1'b0;
        ptr_ready = 1'b0;
        sb_en     = 1'b1;
        fill_halt();
        mem[8'h10] = nrm(32'h10);
        mem[8'h11] = nrm(32'h11);
        mem[8'h12] = nrm(32'h12);

        repeat (2) @(negedge clk);
        check("rst_op", 64'(opcode), 64'd1);
        check("rst_at", 64'(addr_to), 64'(SA));
        check("rst_iv", 64'(instr_valid), 64'd0);
        check("rst_h", 64'(halted), 64'd0);

        nreset = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        check("ign_rdy", 64'(opcode), 64'd1);
        sbq.push_back(32'h10);
        sbq.push_back(32'h11);
        sbq.push_back(32'h12);
        ptr_ready = 1'b1;
        #1;
        check("acc", 64'(opcode), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("iv0", 64'(instr_valid), 64'd1);
        @(negedge clk);
        check("iv1", 64'(instr_valid), 64'd1);
        @(negedge clk);
        check("iv2", 64'(instr_valid), 64'd1);
        @(negedge clk);
        check("hdec_op", 64'(opcode), 64'd1);
        check("hdec_at", 64'(addr_to), 64'h13);
        check("hdec_iv", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check("halted", 64'(halted), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold", 64'({halted, opcode, addr_to, instr_valid}),
                  64'({1'b1, 3'b001, 32'h13, 1'b0}));
        end
        check("q1_drain", 64'(sbq.size()), 64'd0);

        // leave HALTED, then sit in IDLE until a second start
        start = 1'b1;
        #1;
        check("hs_at", 64'(addr_to), 64'(SA));
        @(negedge clk);
        start = 1'b0;
        check("hs_idle", 64'(halted), 64'd0);
        repeat (5) @(negedge clk);
        check("idle_pin", 64'({opcode, addr_to}), 64'({3'b001, SA}));
        sbq.push_back(32'h10);
        sbq.push_back(32'h11);
        sbq.push_back(32'h12);
        go();
        wait_halt("rs_halt");
        check("rs_drain", 64'(sbq.size()), 64'd0);

        // absolute jump with a wrong-path normal word at 0x11
        fill_halt();
        mem[8'h10] = mk(3'b001, 32'h40);
        mem[8'h11] = nrm(32'h11);
        mem[8'h40] = nrm(32'h40);
        do_reset();
        sbq.push_back(32'h40);
        go();
        check("jmp_op", 64'(opcode), 64'd1);
        check("jmp_at", 64'(addr_to), 64'h40);
        @(negedge clk);
        check("jmp_sq", 64'(instr_valid), 64'd0);
        @(negedge clk);
        check("jmp_tgt", 64'(instr_valid), 64'd1);
        wait_halt("jmp_halt");
        check("jmp_drain", 64'(sbq.size()), 64'd0);

        // relative branches, including a zero offset
        fill_halt();
        mem[8'h10] = mk(3'b001, 32'h20);
        mem[8'h11] = nrm(32'h11);
        mem[8'h20] = mk(3'b010, 3);
        mem[8'h21] = nrm(32'h21);
        mem[8'h24] = nrm(32'h24);
        mem[8'h25] = mk(3'b001, 32'h30);
        mem[8'h30] = mk(3'b100, 5);
        mem[8'h31] = nrm(32'h31);
        mem[8'h2C] = nrm(32'h2C);
        mem[8'h2D] = mk(3'b010, 0);
        mem[8'h2E] = nrm(32'h2E);
        do_reset();
        sbq.push_back(32'h24);
        sbq.push_back(32'h2C);
        sbq.push_back(32'h2E);
        go();
        wait_halt("br_halt");
        check("br_hpin", 64'(addr_to), 64'h2F);
        check("br_drain", 64'(sbq.size()), 64'd0);

        // LOOP 3 / DJNZ: body runs three times then falls through
        fill_halt();
        mem[8'h10] = mk(3'b011, 3);
        mem[8'h11] = nrm(32'h11);
        mem[8'h12] = mk(3'b101, 2);
        mem[8'h13] = nrm(32'h13);
        do_reset();
        repeat (3) sbq.push_back(32'h11);
        sbq.push_back(32'h13);
        go();
        wait_halt("l3_halt");
        check("l3_drain", 64'(sbq.size()), 64'd0);

        mem[8'h10] = mk(3'b011, 0);
        do_reset();
        sbq.push_back(32'h11);
        sbq.push_back(32'h13);
        go();
        wait_halt("l0_halt");
        check("l0_drain", 64'(sbq.size()), 64'd0);

        // reset in the middle of a loop clears the counter
        mem[8'h10] = mk(3'b011, 5);
        mem[8'h13] = mk(3'b111, 32'h13);
        do_reset();
        sb_en = 1'b0;
        go();
        repeat (4) @(negedge clk);
        #3;
        nreset = 1'b0;
        #1;
        check("mr_op", 64'(opcode), 64'd1);
        check("mr_at", 64'(addr_to), 64'(SA));
        check("mr_iv", 64'(instr_valid), 64'd0);
        check("mr_h", 64'(halted), 64'd0);
        fill_halt();
        mem[8'h10] = mk(3'b101, 5);
        mem[8'h11] = nrm(32'h11);
        sbq.delete();
        @(negedge clk);
        nreset = 1'b1;
        sb_en  = 1'b1;
        @(negedge clk);
        sbq.push_back(32'h11);
        go();
        wait_halt("mr_halt");
        check("mr_hpin", 64'(addr_to), 64'h12);
        check("mr_drain", 64'(sbq.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
